// File: rtl/alu_exec_unit.sv
// alu_exec_unit: round-robin issue from the ALU reservation station, one
// registered execute stage (S1), and a 2-entry {tag, data} result FIFO
// toward the ROB. Issue is credit-gated so S1 never has to stall.

// Per-entry slice: masks the entry currently held in S1 and drives its clear.
module alu_exec_lane #(
  parameter int idx   = 0,
  parameter int idx_w = 3
) (
  input  logic             ready,
  input  logic             s1_valid,
  input  logic [idx_w-1:0] s1_idx,
  output logic             req,
  output logic             clr
);
  logic held;

  // Entry sitting in S1 is still flagged ready by the station; hide it.
  always_comb begin
    held = s1_valid && (s1_idx == idx_w'(idx));
    req  = ready && !held;
    clr  = held;
  end
endmodule

// ALU / comparator datapath; result is 32-bit and wraps.
module alu_exec_calc (
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic [2:0]  alu_opcode,
  input  logic [2:0]  cmp_opcode,
  input  logic        acu_operation,
  output logic [31:0] result
);
  logic [4:0]  sh;
  logic [31:0] alu_res;
  logic        cmp_res;

  // ALU op, comparator op, then select by acu_operation.
  always_comb begin
    sh      = r2[4:0];
    alu_res = '0;
    cmp_res = 1'b0;
    case (alu_opcode)
      3'd0: alu_res = r1 + r2;
      3'd1: alu_res = r1 << sh;
      3'd2: alu_res = $signed(r1) >>> sh;
      3'd3: alu_res = r1 - r2;
      3'd4: alu_res = r1 ^ r2;
      3'd5: alu_res = r1 >> sh;
      3'd6: alu_res = r1 | r2;
      default: alu_res = r1 & r2;
    endcase
    case (cmp_opcode)
      3'd0: cmp_res = (r1 == r2);
      3'd1: cmp_res = (r1 != r2);
      3'd4: cmp_res = ($signed(r1) <  $signed(r2));
      3'd5: cmp_res = ($signed(r1) >= $signed(r2));
      3'd6: cmp_res = (r1 <  r2);
      3'd7: cmp_res = (r1 >= r2);
      default: cmp_res = 1'b0;
    endcase
    result = acu_operation ? {31'b0, cmp_res} : alu_res;
  end
endmodule

module alu_exec_unit #(
  parameter int size  = 8,
  parameter int tag_w = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [size-1:0]             ready,
  input  logic [size-1:0][31:0]       r1,
  input  logic [size-1:0][31:0]       r2,
  input  logic [size-1:0][tag_w-1:0]  tag,
  input  logic [size-1:0][2:0]        alu_opcode,
  input  logic [size-1:0][2:0]        cmp_opcode,
  input  logic [size-1:0]             acu_operation,
  output logic [size-1:0]             clr,
  output logic                        res_valid,
  output logic [tag_w-1:0]            res_tag,
  output logic [31:0]                 res_data,
  input  logic                        res_ready
);
  localparam int idx_w = (size > 1) ? $clog2(size) : 1;
  localparam int ent_w = tag_w + 32;

  logic [size-1:0]  req;
  logic [idx_w-1:0] rr_ptr, pick, cand;
  logic             found, credit_ok, issue;
  int               c;

  logic             s1_valid;
  logic [idx_w-1:0] s1_idx;
  logic [31:0]      s1_r1, s1_r2;
  logic [tag_w-1:0] s1_tag;
  logic [2:0]       s1_alu_op, s1_cmp_op;
  logic             s1_acu;
  logic [31:0]      s1_result;

  logic [1:0][ent_w-1:0] fifo_mem;
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic             push, pop;
  logic [2:0]       occ;

  for (genvar i = 0; i < size; i++) begin : g_lane
    alu_exec_lane #(.idx(i), .idx_w(idx_w)) u_lane (
      .ready    (ready[i]),
      .s1_valid (s1_valid),
      .s1_idx   (s1_idx),
      .req      (req[i]),
      .clr      (clr[i])
    );
  end

  // First unmasked ready entry at or after rr_ptr, wrapping modulo size.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    c     = 0;
    for (int k = 0; k < size; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= size) c = c - size;
      cand = idx_w'(c);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Credit: FIFO slots already promised (stored + in S1 - leaving) must be < 2.
  always_comb begin
    push      = s1_valid;
    pop       = res_valid && res_ready;
    occ       = {1'b0, count} + {2'b0, s1_valid} - {2'b0, pop};
    credit_ok = (occ < 3'd2);
    issue     = found && credit_ok && !flush;
  end

  // Round-robin pointer advances past whichever entry was issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rr_ptr <= '0;
    else if (flush)  rr_ptr <= '0;
    else if (issue)  rr_ptr <= (pick == idx_w'(size - 1)) ? '0 : pick + 1'b1;
  end

  // S1 capture of the issued entry; valid for exactly one cycle per issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_idx    <= '0;
      s1_r1     <= '0;
      s1_r2     <= '0;
      s1_tag    <= '0;
      s1_alu_op <= '0;
      s1_cmp_op <= '0;
      s1_acu    <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_idx    <= pick;
        s1_r1     <= r1[pick];
        s1_r2     <= r2[pick];
        s1_tag    <= tag[pick];
        s1_alu_op <= alu_opcode[pick];
        s1_cmp_op <= cmp_opcode[pick];
        s1_acu    <= acu_operation[pick];
      end
    end
  end

  alu_exec_calc u_calc (
    .r1            (s1_r1),
    .r2            (s1_r2),
    .alu_opcode    (s1_alu_op),
    .cmp_opcode    (s1_cmp_op),
    .acu_operation (s1_acu),
    .result        (s1_result)
  );

  // Result FIFO: S1 pushes unconditionally, ROB pops on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {s1_tag, s1_result};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Head is zeroed when empty so stale entries never reach the ROB pins.
  always_comb begin
    res_valid           = (count != 2'd0);
    {res_tag, res_data} = res_valid ? fifo_mem[rd_ptr] : '0;
  end

  // The credit rule guarantees S1 never pushes into a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (s1_valid && !flush) |-> (count != 2'd2));

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected {tag,data} pushed at stimulus
// time, popped and compared by an independent monitor on each handshake.
module tb_alu_exec_unit;
  localparam int SIZE = 8;
  localparam int TW   = 4;
  localparam int NV   = 16;

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, res_ready = 1'b1;
  logic [SIZE-1:0]           ready = '0;
  logic [SIZE-1:0][31:0]     r1 = '0, r2 = '0;
  logic [SIZE-1:0][TW-1:0]   tag = '0;
  logic [SIZE-1:0][2:0]      alu_opcode = '0, cmp_opcode = '0;
  logic [SIZE-1:0]           acu_operation = '0;
  logic [SIZE-1:0]           clr;
  logic                      res_valid;
  logic [TW-1:0]             res_tag;
  logic [31:0]               res_data;

  int tests = 0, fails = 0;
  bit auto_clr = 1'b1;
  logic [TW+31:0] exp_q[$];
  logic [TW+31:0] mon_e;
  int issue_log[$];

  logic [2:0]  v_aop[NV] = '{3'd0,3'd3,3'd1,3'd2,3'd5,3'd4,3'd6,3'd7,
                             3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0};
  logic [2:0]  v_cop[NV] = '{3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,
                             3'd0,3'd1,3'd4,3'd6,3'd5,3'd7,3'd2,3'd3};
  logic        v_acu[NV] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,
                             1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1};
  logic [31:0] v_a[NV] = '{32'd5, 32'd3, 32'd1, 32'h80000000, 32'h80000000,
                           32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                           32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF,
                           32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd1};
  logic [31:0] v_b[NV] = '{32'hFFFFFFFF, 32'd5, 32'h21, 32'h24, 32'h24,
                           32'hFF00FF00, 32'h0F0F0000, 32'hFF00FF00,
                           32'd7, 32'd7, 32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd2};
  logic [31:0] v_exp[NV] = '{32'd4, 32'hFFFFFFFE, 32'd2, 32'hF8000000, 32'h08000000,
                             32'h0FF00FF0, 32'hFFFFF0F0, 32'hF000F000,
                             32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0};

  alu_exec_unit #(.size(SIZE), .tag_w(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ready(ready),
    .r1(r1), .r2(r2), .tag(tag),
    .alu_opcode(alu_opcode), .cmp_opcode(cmp_opcode), .acu_operation(acu_operation),
    .clr(clr), .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_log(string name, int k, int want);
    check(name, (issue_log.size() > k) ? issue_log[k] : -1, want);
  endtask

  // One clock; inputs change #1 after the edge. Also logs issues and acts as
  // the station by dropping ready on the entry's clr when auto_clr is set.
  task automatic tick();
    @(posedge clk); #1;
    check("clr_onehot", 32'($countones(clr) <= 1), 32'd1);
    for (int i = 0; i < SIZE; i++)
      if (clr[i]) begin
        issue_log.push_back(i);
        if (auto_clr) ready[i] = 1'b0;
      end
  endtask

  task automatic set_entry(int e, logic [2:0] aop, logic [2:0] cop, logic acu,
                           logic [31:0] a, logic [31:0] b, logic [TW-1:0] t);
    alu_opcode[e] = aop; cmp_opcode[e] = cop; acu_operation[e] = acu;
    r1[e] = a; r2[e] = b; tag[e] = t;
  endtask

  task automatic expect_res(logic [TW-1:0] t, logic [31:0] d);
    exp_q.push_back({t, d});
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  // Scoreboard monitor: compare the FIFO head on every accepted result.
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got tag %0d data %h, none expected", res_tag, res_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({res_tag, res_data} !== mon_e) begin
          fails++;
          $display("FAIL sb_result: got tag %0d data %h want tag %0d data %h",
                   res_tag, res_data, mon_e[TW+31:32], mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_clr", 32'(clr), 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_tag", 32'(res_tag), 0);
    check("rst_data", res_data, 0);
    rst = 1'b1;
    tick();

    // single add on entry 3: clr in N+1, result in N+2
    set_entry(3, 3'd0, 3'd0, 1'b0, 32'd5, 32'hFFFFFFFF, 4'd7);
    expect_res(4'd7, 32'd4);
    ready[3] = 1'b1;
    tick();
    check("single_clr", 32'(clr), 32'h08);
    tick();
    check("single_clr_off", 32'(clr), 0);
    check("single_valid", 32'(res_valid), 1);
    check("single_tag", 32'(res_tag), 7);
    check("single_data", res_data, 32'd4);
    drain();

    // ALU / comparator vectors, one issue per cycle
    for (int v = 0; v < NV; v++) begin
      int e;
      e = v % SIZE;
      set_entry(e, v_aop[v], v_cop[v], v_acu[v], v_a[v], v_b[v], TW'(v));
      expect_res(TW'(v), v_exp[v]);
      ready[e] = 1'b1;
      tick();
      check($sformatf("vec%0d_clr", v), 32'(clr), 32'd1 << e);
    end
    drain();

    // round-robin: 0,2,5 then wrap to 0, then from ptr 1 pick 4 before 0
    @(negedge clk); rst = 1'b0; ready = '0;
    @(posedge clk); #1; rst = 1'b1;
    issue_log.delete();
    for (int i = 0; i < SIZE; i++) set_entry(i, 3'd0, 3'd0, 1'b0, 32'(i), 32'd100, TW'(i));
    expect_res(4'd0, 32'd100); expect_res(4'd2, 32'd102); expect_res(4'd5, 32'd105);
    expect_res(4'd0, 32'd100); expect_res(4'd4, 32'd104); expect_res(4'd0, 32'd100);
    ready[0] = 1'b1; ready[2] = 1'b1; ready[5] = 1'b1;
    repeat (4) tick();
    ready[0] = 1'b1;
    repeat (3) tick();
    ready[0] = 1'b1; ready[4] = 1'b1;
    repeat (4) tick();
    check("rr_count", issue_log.size(), 6);
    check_log("rr_0", 0, 0); check_log("rr_1", 1, 2); check_log("rr_2", 2, 5);
    check_log("rr_wrap", 3, 0); check_log("rr_4", 4, 4); check_log("rr_5", 5, 0);
    drain();

    // backpressure: 4 ready, only 2 may issue while res_ready is low
    do_flush();
    issue_log.delete();
    res_ready = 1'b0;
    expect_res(4'd1, 32'd101); expect_res(4'd3, 32'd103);
    expect_res(4'd4, 32'd104); expect_res(4'd6, 32'd106);
    ready[1] = 1'b1; ready[3] = 1'b1; ready[4] = 1'b1; ready[6] = 1'b1;
    repeat (3) tick();
    check("bp_head_tag_a", 32'(res_tag), 1);
    repeat (5) tick();
    check("bp_issues", issue_log.size(), 2);
    check("bp_valid", 32'(res_valid), 1);
    check("bp_head_tag_b", 32'(res_tag), 1);
    check("bp_head_data", res_data, 32'd101);
    res_ready = 1'b1;
    drain();
    check("bp_total", issue_log.size(), 4);
    check_log("bp_order2", 2, 4); check_log("bp_order3", 3, 6);

    // no double issue: ready[1] held through clr cycle and one more
    issue_log.delete();
    auto_clr = 1'b0;
    expect_res(4'd1, 32'd101); expect_res(4'd1, 32'd101);
    ready[1] = 1'b1;
    tick(); check("nd_c1", 32'(clr), 32'h02);
    tick(); check("nd_c2_masked", 32'(clr), 0);
    tick(); check("nd_c3", 32'(clr), 32'h02);
    ready[1] = 1'b0;
    tick(); check("nd_c4", 32'(clr), 0);
    auto_clr = 1'b1;
    drain();
    check("nd_issues", issue_log.size(), 2);

    // flush with S1 valid and one result queued
    do_flush();
    issue_log.delete();
    res_ready = 1'b0;
    ready[2] = 1'b1; ready[5] = 1'b1;
    tick(); check("fl_clr2", 32'(clr), 32'h04);
    tick(); check("fl_clr5", 32'(clr), 32'h20);
    check("fl_pre_valid", 32'(res_valid), 1);
    flush = 1'b1; ready[3] = 1'b1; ready[7] = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid_off", 32'(res_valid), 0);
    check("fl_clr_off", 32'(clr), 0);
    res_ready = 1'b1;
    expect_res(4'd3, 32'd103); expect_res(4'd7, 32'd107);
    tick(); check("fl_restart_0", 32'(clr), 32'h08);
    drain();

    // async reset between edges
    issue_log.delete();
    res_ready = 1'b0;
    ready[1] = 1'b1; ready[2] = 1'b1;
    tick(); tick();
    check("ar_pre_clr", 32'(clr), 32'h04);
    check("ar_pre_valid", 32'(res_valid), 1);
    @(negedge clk); #2; rst = 1'b0; #1;
    check("ar_clr", 32'(clr), 0);
    check("ar_valid", 32'(res_valid), 0);
    check("ar_tag", 32'(res_tag), 0);
    check("ar_data", res_data, 0);
    ready = '0;
    @(posedge clk); #1; rst = 1'b1; res_ready = 1'b1;
    issue_log.delete();
    expect_res(4'd1, 32'd101); expect_res(4'd6, 32'd106);
    ready[6] = 1'b1; ready[1] = 1'b1;
    drain();
    check_log("ar_ptr0", 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Issue and execute stage directly downstream of the ALU reservation station. Each cycle it picks one ready station entry by round-robin, computes the ALU or comparator result in a registered execute stage, and pulses that entry's clear line back to the station. It delivers `{tag, data}` results to the ROB through a 2-entry result FIFO with a valid/ready handshake.

## Interface
- `size`, default 8: number of reservation-station entries.
- `tag_w`, default 4: ROB tag width.
- `clk  input  1`: clock, rising edge.
- `rst  input  1`: asynchronous, active-low reset.
- `flush  input  1`: synchronous pipeline flush.
- `ready  input  size`: per-entry "both operands resolved and valid" flags from the station.
- `r1[size], r2[size]  input  32 each`: operand values per entry.
- `tag[size]  input  tag_w each`: ROB tag per entry.
- `alu_opcode[size]  input  3 each`: ALU operation per entry.
- `cmp_opcode[size]  input  3 each`: comparator operation per entry.
- `acu_operation[size]  input  1 each`: 1 selects the comparator, 0 selects the ALU.
- `clr  output  size`: one-hot pulse; drives `broadcast_bus[idx].rdy` so the station frees the entry.
- `res_valid  output  1`: result FIFO head is valid.
- `res_tag  output  tag_w`: tag at the FIFO head.
- `res_data  output  32`: result at the FIFO head.
- `res_ready  input  1`: ROB accepts the head this cycle.

## Operation
- **Arithmetic**
  - ALU codes: add=0, sll=1, sra=2, sub=3, xor=4, srl=5, or=6, and=7.
  - Shift amount is `r2[4:0]`. sra is arithmetic; srl and sll are logical.
  - Results are 32-bit and wrap; there is no overflow flag.
- **Comparator**
  - Codes: beq=0, bne=1, blt=4, bge=5, bltu=6, bgeu=7.
  - blt and bge compare signed; bltu and bgeu compare unsigned.
  - Result is `{31'b0, cmp}`. Codes 2 and 3 yield 0.
- **Arbiter**
  - Registered pointer `rr_ptr`.
  - The candidate is the first `idx` at or after `rr_ptr`, wrapping modulo `size`, with `ready[idx]` high and not masked.
  - On issue, `rr_ptr` becomes `(idx+1) mod size`.
- **Execute stage S1**
  - Registers `{s1_valid, s1_idx, r1, r2, tag, opcodes, acu_operation}` on issue.
  - `clr = s1_valid ? (1 << s1_idx) : 0`.
  - Entry `s1_idx` is masked from arbitration while `s1_valid` is high. The station still shows it ready that cycle, and it must not double-issue.
- **Result FIFO**
  - 2 entries, with `count` from 0 to 2.
  - S1 writes its computed result into the FIFO at the end of every cycle that `s1_valid` is high.
  - Pop occurs when `res_valid && res_ready`.
- **Credit rule**: issue only if `count + s1_valid - pop < 2`. The FIFO therefore never overflows, and S1 never stalls.
- **Simultaneous events**
  - Push and pop in the same cycle leave `count` unchanged and preserve order.
  - Push while full cannot occur; it is an assertion target.
- **Flush** (synchronous, highest priority)
  - Clears `s1_valid` and the FIFO (`count` = 0).
  - Sets `rr_ptr` to 0.
  - No issue occurs in the flush cycle.
- **Reset**
  - Asynchronous and immediate, mid-operation included.
  - `s1_valid`=0, `count`=0, `rr_ptr`=0.
  - Outputs: `clr`=0, `res_valid`=0, `res_tag`=0, `res_data`=0.

## Timing
- Entry becomes ready in cycle N and is selected: S1 loads at edge N.
- Cycle N+1: `clr[idx]`=1 for exactly one cycle, and the result is pushed at edge N+1.
- Cycle N+2: `res_valid`=1 if the FIFO was empty. Ready-to-result latency is 2 cycles.
- Throughput: one issue per cycle while `res_ready` stays high.
- With `res_ready` held low, at most 2 results are held in the FIFO. Issue stops once `count` + `s1_valid` reaches 2.
- `res_tag` and `res_data` are stable while `res_valid && !res_ready`.
- `clr` has at most one bit set in any cycle.

## Test plan
- **Single ALU op**
  - Stimulus: entry 3 ready, add, r1=5, r2=0xFFFFFFFF, tag=7, `res_ready`=1.
  - Response: `clr`=0x08 in cycle N+1; `res_valid` with tag 7, data 4 in cycle N+2.
- **Comparator and shift**
  - Signed blt with r1=0xFFFFFFFF, r2=1 gives data 1.
  - bltu with the same operands gives 0.
  - sra with r1=0x80000000, r2=0x24 gives 0xF8000000.
- **Round-robin fairness**
  - Stimulus: entries 0, 2 and 5 ready from reset, each deasserted the cycle after its `clr`.
  - Response: issue order 0, 2, 5; then with 0 ready again and `rr_ptr`=6, it wraps and issues 0.
- **Backpressure**
  - Stimulus: `res_ready`=0 with 4 entries ready.
  - Response: exactly 2 issues, `count`=2, no further `clr`. Raising `res_ready` drains in order with no loss or duplicate.
- **No double issue**
  - Stimulus: hold `ready[1]` high for 2 cycles after its `clr`.
  - Response: exactly one `clr[1]` pulse and one result per arbitration opportunity.
- **Flush/reset mid-flight**
  - Stimulus: flush while S1 is valid and `count`=1.
  - Response: next cycle `res_valid`=0 and `clr`=0; the next issue starts from entry 0.
  - Stimulus: async `rst` low between edges.
  - Response: outputs clear immediately.
